// File: rtl/wavegen_pkg.sv
// Shared types and helpers for the wave generator output path.
package wavegen_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StGap} dac_state_e;

  // Flip the sign bit so the most negative sample maps to the lowest DAC code.
  function automatic logic [SAMPLE_W-1:0] offset_binary(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// Phase divider for the DAC serializer: one-cycle tick every CLK_DIV cycles.
module dac_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] Last = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  assign tick = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_serializer.sv
// Serializes 16-bit samples MSB-first onto cs_n/sclk/sdo through a one-entry holding register.
module dac_serializer
  import wavegen_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned OFFSET_BINARY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                activein,
  output logic                busy,
  output logic                dropped,
  output logic                done,
  output logic                cs_n,
  output logic                sclk,
  output logic                sdo
);

  dac_state_e          state_q, state_d;
  logic                phase_q, phase_d;  // 1 = sclk high half of a bit
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic                consume;
  logic                restart;
  logic                tick;
  logic                cs_n_d, sclk_d, sdo_d, busy_d, done_d, dropped_d;

  // Divider restarts on every state entry and is held cleared while idle.
  assign restart = (state_d != state_q) || (state_q == StIdle);

  dac_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    consume   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hold_valid_q) begin
          state_d = StSetup;
          shreg_d = hold_q;
          consume = 1'b1;
        end
      end
      StSetup: begin
        if (tick) begin
          state_d = StShift;
          phase_d = 1'b1;
        end
      end
      StShift: begin
        if (tick) begin
          if (phase_q) begin
            phase_d = 1'b0;
            shreg_d = {shreg_q[SAMPLE_W-2:0], 1'b0};
          end else if (bit_cnt_q == 4'd15) begin
            state_d = StGap;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            phase_d   = 1'b1;
          end
        end
      end
      StGap: begin
        if (tick) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) begin
      bit_cnt_d = '0;
    end
  end

  // A strobe in the consuming cycle refills hold without counting as a drop.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    dropped_d    = 1'b0;
    if (activein) begin
      hold_d       = (OFFSET_BINARY != 0) ? offset_binary(sample) : sample;
      hold_valid_d = 1'b1;
      dropped_d    = hold_valid_q && !consume;
    end else if (consume) begin
      hold_valid_d = 1'b0;
    end
  end

  always_comb begin
    cs_n_d = !((state_d == StSetup) || (state_d == StShift));
    sclk_d = (state_d == StShift) && phase_d;
    sdo_d  = !cs_n_d && shreg_d[SAMPLE_W-1];
    busy_d = (state_d != StIdle);
    done_d = (state_d == StGap) && (state_q != StGap);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      cs_n         <= 1'b1;
      sclk         <= 1'b0;
      sdo          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      cs_n         <= cs_n_d;
      sclk         <= sclk_d;
      sdo          <= sdo_d;
      busy         <= busy_d;
      done         <= done_d;
      dropped      <= dropped_d;
    end
  end

endmodule

// File: tb/tb_dac_serializer.sv
// Directed bench for dac_serializer: three configurations, a frame-capturing monitor and a scoreboard.
module tb_dac_serializer;

  logic        clk;
  logic        reset;
  logic [15:0] sample;
  logic        activein;
  logic [1:0]  sel;
  logic        act_w  [3];
  logic        busy_w [3];
  logic        drop_w [3];
  logic        done_w [3];
  logic        cs_n_w [3];
  logic        sclk_w [3];
  logic        sdo_w  [3];

  logic        cs_n_m, sclk_m, sdo_m, busy_m, drop_m, done_m;
  int          div_m;

  int          errors;
  int          checks;
  logic [15:0] exp_q[$];
  int          cyc;
  int          drop_cnt;
  int          done_cnt;
  int          mon_bits;
  int          mon_len;
  logic [15:0] mon_word;
  bit          abort;

  assign act_w[0] = activein && (sel == 2'd0);
  assign act_w[1] = activein && (sel == 2'd1);
  assign act_w[2] = activein && (sel == 2'd2);

  assign cs_n_m = cs_n_w[sel];
  assign sclk_m = sclk_w[sel];
  assign sdo_m  = sdo_w[sel];
  assign busy_m = busy_w[sel];
  assign drop_m = drop_w[sel];
  assign done_m = done_w[sel];
  assign div_m  = (sel == 2'd2) ? 1 : 2;

  dac_serializer #(.CLK_DIV(2), .OFFSET_BINARY(0)) u_raw2 (
    .clk(clk), .reset(reset), .sample(sample), .activein(act_w[0]), .busy(busy_w[0]),
    .dropped(drop_w[0]), .done(done_w[0]), .cs_n(cs_n_w[0]), .sclk(sclk_w[0]), .sdo(sdo_w[0])
  );

  dac_serializer #(.CLK_DIV(2), .OFFSET_BINARY(1)) u_ob2 (
    .clk(clk), .reset(reset), .sample(sample), .activein(act_w[1]), .busy(busy_w[1]),
    .dropped(drop_w[1]), .done(done_w[1]), .cs_n(cs_n_w[1]), .sclk(sclk_w[1]), .sdo(sdo_w[1])
  );

  dac_serializer #(.CLK_DIV(1), .OFFSET_BINARY(1)) u_ob1 (
    .clk(clk), .reset(reset), .sample(sample), .activein(act_w[2]), .busy(busy_w[2]),
    .dropped(drop_w[2]), .done(done_w[2]), .cs_n(cs_n_w[2]), .sclk(sclk_w[2]), .sdo(sdo_w[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame monitor: captures sdo on each rising sclk and scores whole frames when cs_n rises.
  initial begin
    logic prev_cs;
    logic prev_sclk;
    int   last_rise;
    prev_cs   = 1'b1;
    prev_sclk = 1'b0;
    last_rise = 0;
    drop_cnt  = 0;
    done_cnt  = 0;
    mon_bits  = 0;
    mon_len   = 0;
    mon_word  = '0;
    forever begin
      @(negedge clk);
      if (!cs_n_m && prev_cs) begin
        mon_len  = 1;
        mon_bits = 0;
        mon_word = '0;
      end else if (!cs_n_m) begin
        mon_len = mon_len + 1;
      end
      if (sclk_m && !prev_sclk && !cs_n_m) begin
        if (mon_bits != 0) chk("sclk_period", cyc - last_rise, 2 * div_m);
        last_rise = cyc;
        mon_word  = {mon_word[14:0], sdo_m};
        mon_bits  = mon_bits + 1;
      end
      if (cs_n_m && !prev_cs) begin
        if (abort) begin
          abort = 1'b0;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          chk("done_at_frame_end", done_m, 1);
          chk("frame_bits", mon_bits, 16);
          chk("frame_len", mon_len, 33 * div_m);
          if (exp_q.size() == 0) chk("frame_unexpected", 1, 0);
          else chk("frame_word", mon_word, exp_q.pop_front());
        end
      end
      if (drop_m) drop_cnt = drop_cnt + 1;
      if (done_m) done_cnt = done_cnt + 1;
      prev_cs   = cs_n_m;
      prev_sclk = sclk_m;
    end
  end

  task automatic pulse(input logic [15:0] v, input logic [15:0] e, input bit push);
    sample   = v;
    activein = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    activein = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while ((busy_m || exp_q.size() != 0) && n < max) begin
      @(negedge clk);
      n = n + 1;
    end
    chk(tag, busy_m || (exp_q.size() != 0), 0);
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int n0;
    int n;
    errors   = 0;
    checks   = 0;
    sel      = 2'd0;
    reset    = 1'b1;
    activein = 1'b0;
    sample   = '0;
    abort    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(1);

    chk("rst_cs_n", cs_n_m, 1);
    chk("rst_sclk", sclk_m, 0);
    chk("rst_sdo", sdo_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_dropped", drop_m, 0);
    chk("rst_done", done_m, 0);

    // Raw word, latency and single done per frame.
    n0 = done_cnt;
    pulse(16'h1234, 16'h1234, 1'b1);
    chk("cs_n_after_strobe", cs_n_m, 1);
    idle(1);
    chk("cs_n_fall", cs_n_m, 0);
    chk("sdo_first_bit", sdo_m, 0);
    wait_idle("idle_raw", 300);
    chk("done_once", done_cnt - n0, 1);

    // Offset binary corner codes.
    sel = 2'd1;
    d0  = drop_cnt;
    pulse(16'h8000, 16'h0000, 1'b1);
    idle(99);
    pulse(16'h0000, 16'h8000, 1'b1);
    idle(99);
    pulse(16'h7FFF, 16'hFFFF, 1'b1);
    wait_idle("idle_ob", 300);
    chk("ob_no_drops", drop_cnt - d0, 0);

    // Overwrite of an unsent held sample.
    sel = 2'd0;
    d0  = drop_cnt;
    pulse(16'h1111, 16'h1111, 1'b1);
    idle(4);
    pulse(16'h2222, 16'h0000, 1'b0);
    chk("no_drop_first_fill", drop_m, 0);
    idle(4);
    pulse(16'h3333, 16'h3333, 1'b1);
    chk("drop_pulse", drop_m, 1);
    idle(1);
    chk("drop_one_cycle", drop_m, 0);
    wait_idle("idle_drop", 400);
    chk("drop_count", drop_cnt - d0, 1);

    // Strobe in the same cycle hold is consumed.
    d0 = drop_cnt;
    pulse(16'hA001, 16'hA001, 1'b1);
    pulse(16'h0B02, 16'h0B02, 1'b1);
    chk("coincide_no_drop", drop_m, 0);
    wait_idle("idle_coincide", 400);
    chk("coincide_drops", drop_cnt - d0, 0);

    // Asynchronous reset in the middle of SHIFT.
    sel = 2'd1;
    pulse(16'h4321, 16'hC321, 1'b1);
    n = 0;
    while (!(!cs_n_m && mon_bits == 7) && n < 300) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("reach_bit7", mon_bits, 7);
    abort = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_cs_n", cs_n_m, 1);
    chk("async_sclk", sclk_m, 0);
    chk("async_busy", busy_m, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    chk("abort_consumed", exp_q.size(), 0);
    pulse(16'h00FF, 16'h80FF, 1'b1);
    wait_idle("idle_after_reset", 300);

    // Back-to-back frames at the fastest divider.
    sel = 2'd2;
    d0  = drop_cnt;
    pulse(16'h0001, 16'h8001, 1'b1);
    idle(34);
    pulse(16'hFFFF, 16'h7FFF, 1'b1);
    idle(34);
    pulse(16'h5A5A, 16'hDA5A, 1'b1);
    idle(34);
    pulse(16'hA5A5, 16'h25A5, 1'b1);
    wait_idle("idle_div1", 300);
    chk("div1_no_drops", drop_cnt - d0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
